array_bubble_sort: RTL and testbench

//  In-place sorter for arrays held in the lab register file; the writer-side counterpart of the sorted-array checker.

---
 rtl/array_bubble_sort.sv | 141 ++++++++++++++
 tb/tb_array_bubble_sort.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/array_bubble_sort.sv
// In-place bubble sort of rf[array .. array+length-1] through two async read ports and one write port.
// Latency: an already-sorted N>=2 array is done N edges after go is accepted; each swap adds 2, each extra pass adds N.
// No backpressure: go is taken only in IDLE/DONE and ignored while busy. Optional macro SORT_SWAP_COUNT_EN adds swap_count.
module array_bubble_sort #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
`ifdef SORT_SWAP_COUNT_EN
  ,
  parameter int CNT_W  = 8
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W-1:0] array,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  input  logic [DATA_W-1:0] rd_data1,
  input  logic [DATA_W-1:0] rd_data2,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
`ifdef SORT_SWAP_COUNT_EN
  ,
  output logic [CNT_W-1:0]  swap_count
`endif
);

  typedef enum logic [2:0] {IDLE, CMP, SWA, SWB, PEND, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, last, base;
  logic              swapped;
  logic [DATA_W-1:0] tmp_lo, tmp_hi;
  logic              out_of_order;
  logic              at_last;
  logic              start;

  // Neighbour pair read straight from the rf; addresses wrap naturally at ADDR_W bits.
  assign rd_addr1     = idx;
  assign rd_addr2     = idx + 1'b1;
  assign out_of_order = $signed(rd_data1) > $signed(rd_data2);
  assign at_last      = (idx == last);
  assign start        = go && (state == IDLE || state == DONE);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and rf write-port / status outputs.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_addr   = idx;
    wr_data   = tmp_hi;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        busy = 1'b0;
        done = (state == DONE);
        if (go) state_nxt = (length <= ADDR_W'(1)) ? DONE : CMP;
      end
      CMP: begin
        if (out_of_order) state_nxt = SWA;
        else if (at_last) state_nxt = PEND;
      end
      SWA: begin
        wr_en     = 1'b1;
        state_nxt = SWB;
      end
      SWB: begin
        wr_en     = 1'b1;
        wr_addr   = idx + 1'b1;
        wr_data   = tmp_lo;
        state_nxt = at_last ? PEND : CMP;
      end
      PEND: begin
        state_nxt = swapped ? CMP : DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pass bookkeeping: current index, last pair of the pass, swap flag and the held pair.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx     <= '0;
      last    <= '0;
      base    <= '0;
      swapped <= 1'b0;
      tmp_lo  <= '0;
      tmp_hi  <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (go) begin
            base    <= array;
            idx     <= array;
            last    <= array + length - ADDR_W'(2);
            swapped <= 1'b0;
          end
        end
        CMP: begin
          if (out_of_order) begin
            tmp_lo  <= rd_data1;
            tmp_hi  <= rd_data2;
            swapped <= 1'b1;
          end else if (!at_last) begin
            idx <= idx + 1'b1;
          end
        end
        SWB: begin
          if (!at_last) idx <= idx + 1'b1;
        end
        PEND: begin
          if (swapped) begin
            idx     <= base;
            swapped <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SORT_SWAP_COUNT_EN
  // Saturating count of completed swaps; cleared on each accepted go, frozen in DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                      swap_count <= '0;
    else if (start)                                 swap_count <= '0;
    else if (state == SWB && swap_count != '1)      swap_count <= swap_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_array_bubble_sort.sv
// Bench for array_bubble_sort: rf model with async reads, write scoreboard fed by a software bubble sort,
// table of sort cases with hand-computed sorted results and done latencies, plus a reset-mid-swap sequence.
module tb_array_bubble_sort;

  logic        clock = 1'b0;
  logic        reset;
  logic        go;
  logic [4:0]  array, length;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy, done;
`ifdef SORT_SWAP_COUNT_EN
  logic [7:0]  swap_count;
`endif

  array_bubble_sort dut (
    .clock(clock), .reset(reset), .go(go), .array(array), .length(length),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
`ifdef SORT_SWAP_COUNT_EN
    , .swap_count(swap_count)
`endif
  );

  always #5 clock = ~clock;

  // Register file: async reads, one write per edge; bench preload path when the DUT is not writing.
  logic [31:0] rf [32];
  logic [31:0] mdl [32];
  logic        ld_en = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [31:0] ld_val = '0;
  assign rd_data1 = rf[rd_addr1];
  assign rd_data2 = rf[rd_addr2];
  always @(posedge clock) begin
    if (wr_en)      rf[wr_addr] <= wr_data;
    else if (ld_en) rf[ld_addr] <= ld_val;
  end

  int checks = 0;
  int failures = 0;
  logic [36:0] exp_q[$];
  bit busy_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Every DUT write is popped against the scoreboard.
  always @(negedge clock) begin
    if (busy) busy_seen = 1;
    if (!reset && wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: addr %0d data %0h, none expected", wr_addr, wr_data);
      end else begin
        chk("write", 64'({wr_addr, wr_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic load(input logic [4:0] a, input logic [31:0] v);
    @(negedge clock);
    ld_en = 1'b1; ld_addr = a; ld_val = v;
    @(posedge clock);
    #1 ld_en = 1'b0;
    mdl[a] = v;
  endtask

  // Reference bubble sort on the bench copy; queues every write it would make.
  task automatic model_sort(input logic [4:0] b, input logic [4:0] n);
    bit again;
    logic [4:0] a0, a1;
    logic [31:0] t;
    if (n < 5'd2) return;
    do begin
      again = 0;
      for (int i = 0; i < int'(n) - 1; i++) begin
        a0 = b + 5'(i);
        a1 = a0 + 5'd1;
        if ($signed(mdl[a0]) > $signed(mdl[a1])) begin
          exp_q.push_back({a0, mdl[a1]});
          exp_q.push_back({a1, mdl[a0]});
          t = mdl[a0]; mdl[a0] = mdl[a1]; mdl[a1] = t;
          again = 1;
        end
      end
    end while (again);
  endtask

  task automatic start_go(input logic [4:0] b, input logic [4:0] n);
    busy_seen = 0;
    @(negedge clock);
    go = 1'b1; array = b; length = n;
    @(posedge clock);
    #1 go = 1'b0; array = ~b; length = ~n;
  endtask

  task automatic compare_rf(input string nm);
    int bad = 0;
    for (int i = 0; i < 32; i++) if (rf[i] !== mdl[i]) bad++;
    chk(nm, 64'(bad), 64'd0);
  endtask

  // Edges counted include the one that accepted go.
  task automatic run(input logic [4:0] b, input logic [4:0] n, input int exp_edges, input int exp_swaps, input string nm);
    int edges;
    model_sort(b, n);
    start_go(b, n);
    edges = 1;
    while (!done && edges < 400) begin
      @(posedge clock); #1 edges++;
    end
    chk({nm, "_done"}, 64'(done), 64'd1);
    chk({nm, "_edges"}, 64'(edges), 64'(exp_edges));
    chk({nm, "_busy_seen"}, 64'(busy_seen), 64'(n > 5'd1));
    @(posedge clock); #1;
    chk({nm, "_done_held"}, 64'(done), 64'd1);
    chk({nm, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    compare_rf({nm, "_rf_vs_model"});
`ifdef SORT_SWAP_COUNT_EN
    chk({nm, "_swap_count"}, 64'(swap_count), 64'(exp_swaps));
`else
    if (exp_swaps < 0) $display("negative swap expectation in %s", nm);
`endif
  endtask

  typedef struct packed {
    logic [4:0]        base;
    logic [4:0]        len;
    logic [4:0][31:0]  vals;
    logic [4:0][31:0]  srt;
    int                edges;
    int                swaps;
  } vec_t;

  vec_t vecs [7];

  task automatic set_vec(input int k, input logic [4:0] b, input logic [4:0] n, input int e, input int s,
                         input logic [31:0] v0, v1, v2, v3, v4, s0, s1, s2, s3, s4);
    vecs[k].base = b; vecs[k].len = n; vecs[k].edges = e; vecs[k].swaps = s;
    vecs[k].vals = {v4, v3, v2, v1, v0};
    vecs[k].srt  = {s4, s3, s2, s1, s0};
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; array = '0; length = '0;
    set_vec(0, 5'd11, 5'd5,  6, 0, 11, 12, 13, 14, 15,  11, 12, 13, 14, 15);
    set_vec(1, 5'd2,  5'd5, 13, 1,  1,  2,  3,  2,  5,   1,  2,  2,  3,  5);
    set_vec(2, 5'd30, 5'd4, 29, 6,  9,  8,  7,  6,  0,   6,  7,  8,  9,  0);
    set_vec(3, 5'd7,  5'd0,  1, 0,  0,  0,  0,  0,  0,   0,  0,  0,  0,  0);
    set_vec(4, 5'd7,  5'd1,  1, 0, 42,  0,  0,  0,  0,  42,  0,  0,  0,  0);
    set_vec(5, 5'd12, 5'd2,  3, 0, 32'hFFFF_FFFF, 1, 0, 0, 0,  32'hFFFF_FFFF, 1, 0, 0, 0);
    set_vec(6, 5'd20, 5'd3, 14, 2,  5,  5, 32'hFFFF_FFFD, 0, 0,  32'hFFFF_FFFD, 5, 5, 0, 0);

    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_rd_addr1", 64'(rd_addr1), 64'd0);
    chk("rst_rd_addr2", 64'(rd_addr2), 64'd1);
`ifdef SORT_SWAP_COUNT_EN
    chk("rst_swap_count", 64'(swap_count), 64'd0);
`endif
    for (int i = 0; i < 32; i++) load(5'(i), 32'(i));
    @(negedge clock) reset = 1'b0;

    for (int k = 0; k < 7; k++) begin
      for (int j = 0; j < int'(vecs[k].len); j++) load(vecs[k].base + 5'(j), vecs[k].vals[j]);
      run(vecs[k].base, vecs[k].len, vecs[k].edges, vecs[k].swaps, $sformatf("vec%0d", k));
      for (int j = 0; j < int'(vecs[k].len); j++)
        chk($sformatf("vec%0d_sorted%0d", k, j), 64'(rf[vecs[k].base + 5'(j)]), 64'(vecs[k].srt[j]));
    end

    // Reset while the second half of the only swap is on the write port.
    begin
      int cyc = 0;
      load(5'd2, 1); load(5'd3, 2); load(5'd4, 3); load(5'd5, 2); load(5'd6, 5);
      model_sort(5'd2, 5'd5);
      start_go(5'd2, 5'd5);
      while (!(wr_en && wr_addr == 5'd5) && cyc < 100) begin
        @(posedge clock); #1 cyc++;
      end
      chk("rst_mid_reached_swb", 64'(wr_en && wr_addr == 5'd5), 64'd1);
      reset = 1'b1;
      #1;
      chk("rst_mid_wr_en", 64'(wr_en), 64'd0);
      chk("rst_mid_done", 64'(done), 64'd0);
      chk("rst_mid_busy", 64'(busy), 64'd0);
`ifdef SORT_SWAP_COUNT_EN
      chk("rst_mid_swap_count", 64'(swap_count), 64'd0);
`endif
      exp_q.delete();
      @(negedge clock) reset = 1'b0;
      // First half of the swap landed, the second did not: the 3 is lost.
      mdl[2] = 1; mdl[3] = 2; mdl[4] = 2; mdl[5] = 2; mdl[6] = 5;
      compare_rf("rst_mid_rf_after_reset");
      run(5'd2, 5'd5, 6, 0, "rerun");
      for (int j = 2; j < 6; j++)
        chk($sformatf("rerun_ordered%0d", j), 64'($signed(rf[j]) <= $signed(rf[j+1])), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
